pll_cfg_sequencer: RTL and testbench

Sits between the SPI slave frame receiver and the PLL ring inside the PLL map top level. Accepts decoded 512-bit command frames (read, write, pllen and ratio fields) and applies ratio and enable changes to the PLL with a one-cycle update strobe. After each change it waits out a settle window, then waits for lock or a timeout. When a read is requested it returns a status frame for SPI transmit.

---
 rtl/pll_cfg_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_pll_cfg_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_cfg_sequencer.sv
// PLL configuration sequencer: takes decoded SPI command frames, applies
// ratio/enable changes to the PLL ring, waits for settle and lock (or a
// timeout), and optionally returns a status frame for SPI transmit.
module pll_cfg_sequencer #(
  parameter int DATA_WIDTH    = 512,
  parameter int RATIO_W       = 10,
  parameter int DEFAULT_RATIO = 6,
  parameter int SETTLE_CYC    = 16,
  parameter int LOCK_TIMEOUT  = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_valid,
  input  logic [DATA_WIDTH-1:0] frame_data,
  output logic                  frame_ready,
  output logic                  pll_en,
  output logic [RATIO_W-1:0]    pll_ratio,
  output logic                  pll_valid,
  input  logic                  pll_lock,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  input  logic                  rsp_ready,
  output logic                  busy,
  output logic                  err_timeout
);

  localparam int CNT_MAX = (SETTLE_CYC > LOCK_TIMEOUT) ? SETTLE_CYC : LOCK_TIMEOUT;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_WAIT_LOCK,
    S_RESP
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  rd_q, rd_d;
  logic                  pllen_q, pllen_d;
  logic                  applied_q, applied_d;
  logic                  ratio_err_q, ratio_err_d;
  logic                  err_timeout_q, err_timeout_d;
  logic                  pll_en_q, pll_en_d;
  logic [RATIO_W-1:0]    pll_ratio_q, pll_ratio_d;
  logic                  pll_valid_q, pll_valid_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  lock_meta_q, lock_s_q;

  // Frame field decode; bits above the ratio field carry nothing for us.
  logic               f_rd, f_wr, f_pllen;
  logic [RATIO_W-1:0] f_ratio;
  logic               unused_frame_bits;

  assign f_rd    = frame_data[0];
  assign f_wr    = frame_data[1];
  assign f_pllen = frame_data[2];
  assign f_ratio = frame_data[3 +: RATIO_W];
  assign unused_frame_bits = ^frame_data[DATA_WIDTH-1:3+RATIO_W];

  // Next-state and datapath: the new PLL config and its strobe are set on the
  // transition into APPLY so the strobe coincides with the new values.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rd_d          = rd_q;
    pllen_d       = pllen_q;
    applied_d     = applied_q;
    ratio_err_d   = ratio_err_q;
    err_timeout_d = err_timeout_q;
    pll_en_d      = pll_en_q;
    pll_ratio_d   = pll_ratio_q;
    pll_valid_d   = 1'b0;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;

    case (state_q)
      S_IDLE: begin
        if (frame_valid) begin
          rd_d      = f_rd;
          pllen_d   = f_pllen;
          applied_d = f_wr && (f_ratio != '0);
          cnt_d     = '0;
          if (f_wr && (f_ratio != '0)) begin
            state_d     = S_APPLY;
            pll_en_d    = f_pllen;
            pll_ratio_d = f_ratio;
            pll_valid_d = 1'b1;
            ratio_err_d = 1'b0;
          end else if (f_wr) begin
            // Zero ratio is illegal: flag it, keep the current config.
            ratio_err_d = 1'b1;
            state_d     = f_rd ? S_RESP : S_IDLE;
          end else if (f_rd) begin
            state_d = S_RESP;
          end
        end
      end
      S_APPLY: begin
        cnt_d = '0;
        if (pllen_q) state_d = S_SETTLE;
        else         state_d = rd_q ? S_RESP : S_IDLE;
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = S_WAIT_LOCK;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        // Lock is checked first so it wins over a coincident timeout.
        if (lock_s_q) begin
          err_timeout_d = 1'b0;
          state_d       = rd_q ? S_RESP : S_IDLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          err_timeout_d = 1'b1;
          state_d       = rd_q ? S_RESP : S_IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Status is snapshotted on entry to RESP using the post-update flags.
    if (state_d == S_RESP && state_q != S_RESP) begin
      rsp_valid_d                = 1'b1;
      rsp_data_d                 = '0;
      rsp_data_d[0]              = 1'b1;
      rsp_data_d[1]              = applied_d;
      rsp_data_d[2]              = pll_en_d;
      rsp_data_d[3 +: RATIO_W]   = pll_ratio_d;
      rsp_data_d[3+RATIO_W]      = lock_s_q;
      rsp_data_d[4+RATIO_W]      = err_timeout_d;
      rsp_data_d[5+RATIO_W]      = ratio_err_d;
    end
  end

  // State, config and response registers plus the 2-FF lock synchroniser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      rd_q          <= 1'b0;
      pllen_q       <= 1'b0;
      applied_q     <= 1'b0;
      ratio_err_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      pll_en_q      <= 1'b0;
      pll_ratio_q   <= RATIO_W'(DEFAULT_RATIO);
      pll_valid_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      lock_meta_q   <= 1'b0;
      lock_s_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rd_q          <= rd_d;
      pllen_q       <= pllen_d;
      applied_q     <= applied_d;
      ratio_err_q   <= ratio_err_d;
      err_timeout_q <= err_timeout_d;
      pll_en_q      <= pll_en_d;
      pll_ratio_q   <= pll_ratio_d;
      pll_valid_q   <= pll_valid_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      lock_meta_q   <= pll_lock;
      lock_s_q      <= lock_meta_q;
    end
  end

  assign frame_ready = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign pll_en      = pll_en_q;
  assign pll_ratio   = pll_ratio_q;
  assign pll_valid   = pll_valid_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_pll_cfg_sequencer.sv
// Scoreboard bench for pll_cfg_sequencer: a frame-level model predicts PLL
// config updates and status frames; monitors compare as the DUT presents them.
module tb_pll_cfg_sequencer;
  localparam int DW = 512, RW = 10, SETTLE = 16, TO = 4096, BOUND = 6000;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          frame_valid = 1'b0, pll_lock = 1'b0, rsp_ready = 1'b0;
  logic [DW-1:0] frame_data = '0;
  logic          frame_ready, pll_en, pll_valid, rsp_valid, busy, err_timeout;
  logic [RW-1:0] pll_ratio;
  logic [DW-1:0] rsp_data;

  pll_cfg_sequencer dut (
    .clk(clk), .rst_n(rst_n), .frame_valid(frame_valid), .frame_data(frame_data),
    .frame_ready(frame_ready), .pll_en(pll_en), .pll_ratio(pll_ratio),
    .pll_valid(pll_valid), .pll_lock(pll_lock), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_ready(rsp_ready), .busy(busy), .err_timeout(err_timeout)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;
  bit hold_ready = 1'b0;

  // Reference model state: current PLL config and sticky flags.
  bit          m_en = 0, m_to = 0, m_rerr = 0;
  logic [RW-1:0] m_ratio = 10'd6;
  logic [15:0] rsp_q[$];
  logic [RW:0] pll_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Frame-level rules: a nonzero-ratio write reconfigures; an enabled write
  // ends locked (lvl=1) or timed out (lvl=0); a read reports the result.
  function automatic void model(input bit rd, wr, en, input logic [RW-1:0] ratio, input bit lvl);
    bit app;
    app = wr && (ratio != 0);
    if (app) begin
      m_en = en; m_ratio = ratio; m_rerr = 0;
      pll_q.push_back({en, ratio});
      if (en) m_to = !lvl;
    end else if (wr) m_rerr = 1;
    if (rd) rsp_q.push_back({m_rerr, m_to, lvl, m_ratio, m_en, app, 1'b1});
  endfunction

  task automatic send(input bit rd, wr, en, input logic [RW-1:0] ratio, input bit lvl,
                      output int waited);
    logic [DW-1:0] d;
    model(rd, wr, en, ratio, lvl);
    for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = $urandom();
    d[0] = rd; d[1] = wr; d[2] = en; d[3 +: RW] = ratio;
    frame_data = d;
    frame_valid = 1'b1;
    waited = 0;
    forever begin
      @(negedge clk);
      if (frame_ready) break;
      waited++;
      if (waited > BOUND) begin
        check("frame_accept_timeout", frame_ready, 1);
        frame_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    frame_valid = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!frame_ready && cyc < BOUND);
    if (!frame_ready) check("idle_timeout", frame_ready, 1);
  endtask

  task automatic check_cfg(input string tag);
    check({tag, "_pll_en"}, pll_en, m_en);
    check({tag, "_pll_ratio"}, pll_ratio, m_ratio);
    check({tag, "_err_timeout"}, err_timeout, m_to);
  endtask

  // Response-side handshake driver.
  initial forever begin
    @(posedge clk); #1;
    rsp_ready = hold_ready ? 1'b0 : ($urandom_range(0, 2) != 0);
  end

  // Monitor: PLL update strobes, status frames and response stability.
  initial begin
    bit            prev_valid = 0, prev_hs = 0;
    logic [DW-1:0] prev_data = '0;
    logic [RW:0]   pe;
    logic [15:0]   re;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 0;
        continue;
      end
      if (pll_valid) begin
        if (pll_q.size() == 0) check("pll_valid_unexpected", pll_valid, 0);
        else begin
          pe = pll_q.pop_front();
          check("pll_update", {pll_en, pll_ratio}, pe);
        end
      end
      if (rsp_valid && prev_valid && !prev_hs)
        check("rsp_data_stable", rsp_data == prev_data, 1);
      if (rsp_valid && rsp_ready) begin
        if (rsp_q.size() == 0) check("rsp_unexpected", rsp_valid, 0);
        else begin
          re = rsp_q.pop_front();
          check("rsp_status", rsp_data[15:0], re);
          check("rsp_upper_zero", |rsp_data[DW-1:16], 0);
        end
      end
      prev_valid = rsp_valid;
      prev_hs    = rsp_valid && rsp_ready;
      prev_data  = rsp_data;
    end
  end

  initial begin
    int w, cyc;
    bit rd, wr, en, lvl;
    logic [RW-1:0] ratio;

    // Reset values.
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_pll_ratio", pll_ratio, 6);
    check("rst_pll_en", pll_en, 0);
    check("rst_frame_ready", frame_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err_timeout", err_timeout, 0);
    check("rst_rsp_data", rsp_data[63:0], 0);
    repeat (10) @(posedge clk);
    #1;

    // Enabled write, lock rises 30 cycles after acceptance.
    send(0, 1, 1, 10'd11, 1, w);
    repeat (29) @(posedge clk);
    #1 pll_lock = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("lock_busy_still_high", busy, 1);
    @(posedge clk);
    @(negedge clk);
    check("lock_busy_released", busy, 0);
    check_cfg("write_lock");

    // Read+write with no lock: full timeout.
    @(posedge clk); #1 pll_lock = 1'b0;
    repeat (4) @(posedge clk); #1;
    send(1, 1, 1, 10'd11, 0, w);
    wait_idle(cyc);
    check("timeout_duration", cyc > SETTLE + TO, 1);
    check_cfg("timeout");
    @(posedge clk); #1 pll_lock = 1'b1;
    repeat (4) @(posedge clk); #1;
    send(1, 1, 1, 10'd11, 1, w);
    wait_idle(cyc);
    check_cfg("relock");

    // Zero-ratio write with read.
    @(posedge clk); #1;
    send(1, 1, 1, 10'd0, 1, w);
    wait_idle(cyc);
    check_cfg("ratio_zero");

    // Back-pressure during WAIT_LOCK, and a stalled response.
    @(posedge clk); #1 pll_lock = 1'b0;
    repeat (4) @(posedge clk); #1;
    fork
      begin
        send(1, 1, 1, 10'd77, 1, w);
        send(1, 0, 0, 10'd5, 1, w);
        check("backpressure_wait", w > SETTLE, 1);
      end
      begin
        repeat (40) @(posedge clk);
        #1 pll_lock = 1'b1;
      end
      begin
        hold_ready = 1'b1;
        cyc = 0;
        while (!rsp_valid && cyc < 200) begin @(negedge clk); cyc++; end
        check("hold_rsp_seen", rsp_valid, 1);
        repeat (10) @(posedge clk);
        hold_ready = 1'b0;
      end
    join
    wait_idle(cyc);
    check_cfg("backpressure");

    // Reset during SETTLE.
    @(posedge clk); #1;
    send(0, 1, 1, 10'd200, 1, w);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    m_en = 0; m_ratio = 10'd6; m_to = 0; m_rerr = 0;
    check("midrst_busy", busy, 0);
    check("midrst_frame_ready", frame_ready, 1);
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_pll_valid", pll_valid, 0);
    check_cfg("midrst");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk); #1;
    send(1, 1, 1, 10'd300, 1, w);
    wait_idle(cyc);
    check_cfg("post_rst");

    // Randomised frames against the model.
    for (int n = 0; n < 40; n++) begin
      rd    = $urandom_range(0, 1);
      wr    = ($urandom_range(0, 3) != 0);
      en    = $urandom_range(0, 1);
      ratio = ($urandom_range(0, 5) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
      lvl   = ($urandom_range(0, 7) != 0);
      @(posedge clk); #1 pll_lock = lvl;
      repeat (4) @(posedge clk); #1;
      send(rd, wr, en, ratio, lvl, w);
      wait_idle(cyc);
      check_cfg("rand");
    end

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rsp_queue_drained", rsp_q.size(), 0);
    check("pll_queue_drained", pll_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
